loop_ctrl: RTL

Loop-control stage that drives the 8-bit loop-count register's write port and consumes that register's read value.
- Decodes three strobes from the decoder: SETCNT, LOOPBEG and LOOPEND.
- Records the loop-start PC and performs decrement-and-branch.
- Issues the backward branch to fetch over a valid/ready handshake.
- Single loop level; no nesting.

---
 rtl/loop_ctrl_pkg.sv | 6 +
 rtl/loop_ctrl_if.sv | 12 +
 rtl/loop_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/loop_ctrl_pkg.sv
// loop_ctrl_pkg: shared widths and FSM state type for the loop-control stage
package loop_ctrl_pkg;
  localparam int CNT_W = 8;
  localparam int PC_W = 10;
  typedef enum logic [1:0] {IDLE, ARMED, BRANCH} loop_state_t;
endpackage

// File: rtl/loop_ctrl_if.sv
// loop_ctrl_if: count-register port and backward-branch handshake to fetch
interface loop_ctrl_if;
  import loop_ctrl_pkg::*;
  logic br_valid;
  logic br_ready;
  logic [PC_W-1:0] br_target;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_di;
  logic cnt_we;
  modport master(output br_valid, br_target, cnt_di, cnt_we, input br_ready, cnt_q);
  modport slave(input br_valid, br_target, cnt_di, cnt_we, output br_ready, cnt_q);
endinterface

// File: rtl/loop_ctrl.sv
// loop_ctrl: single-level loop FSM with decrement-and-branch to fetch.
// Define LOOP_CTRL_ITER_CNT_EN to add the saturating perf_iters branch counter.
module loop_ctrl
  import loop_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic op_setcnt,
  input  logic op_loopbeg,
  input  logic op_loopend,
  input  logic [CNT_W-1:0] data_in,
  input  logic [PC_W-1:0] pc,
  loop_ctrl_if.master bus,
  output logic hold,
  output logic armed,
  output logic err
`ifdef LOOP_CTRL_ITER_CNT_EN
  ,
  output logic [15:0] perf_iters
`endif
);
  loop_state_t state, state_nx;
  logic [PC_W-1:0] start_pc;
  logic eff, set, beg, lend, dec, err_nx;
  always_comb begin
    eff = !stall && state != BRANCH;
    set = eff && op_setcnt;
    beg = eff && !op_setcnt && op_loopbeg;
    lend = eff && !op_setcnt && !op_loopbeg && op_loopend && state == ARMED;
    dec = lend && bus.cnt_q != '0;
    err_nx = eff && ((op_setcnt && (op_loopbeg || op_loopend)) || (op_loopbeg && op_loopend)
      || (beg && state == ARMED)
      || (op_loopend && !op_setcnt && !op_loopbeg && state == IDLE));
    bus.cnt_we = set || dec;
    bus.cnt_di = set ? data_in : dec ? bus.cnt_q - 1'b1 : '0;
    state_nx = beg ? ARMED
             : lend ? (bus.cnt_q > CNT_W'(1) ? BRANCH : IDLE)
             : (state == BRANCH && bus.br_ready) ? ARMED
             : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      start_pc <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (beg) start_pc <= pc + 1'b1;
      if (err_nx) err <= 1'b1;
    end
  end
  // branch outputs decode straight from the state flop so reset drops them at once
  assign bus.br_valid = state == BRANCH;
  assign bus.br_target = start_pc;
  assign hold = state == BRANCH;
  assign armed = state != IDLE;
`ifdef LOOP_CTRL_ITER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_iters <= '0;
    else if (bus.br_valid && bus.br_ready && perf_iters != 16'hFFFF) perf_iters <= perf_iters + 1'b1;
  end
`endif
endmodule
